control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, data/instruction width; AWIDTH, default 8, address width; TIMEOUT, default 16, maximum memory-wait cycles.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 data  in  WIDTH  data bus as seen by the controller; instruction word during fetch.
REQ-005 Valid  in  1  memory completion strobe for the current request; one cycle per completion.
REQ-006 opcode, oppA, oppB, literal  out  6/5/5/WIDTH  datapath operand fields.
REQ-007 regEn, increment, wrData, wrAdd  out  1 each  write strobes for the register file, PC, data register and address register.
REQ-008 fetch, Branch_En, store_en, DataBus_En, AddCon, DataCon  out  1 each  datapath mux and bus-drive selects.
REQ-009 mem_req, mem_we  out  1 each  memory request and write qualifier.
REQ-010 halted, error  out  1 each  sticky status flags.

Function
REQ-011 Instruction format SHALL be: opcode = IR[31:26]; oppA = IR[25:21]; oppB = IR[20:16]; literal = IR[15:0], sign-extended to WIDTH.
REQ-012 Opcode classes SHALL be:
- 00xxxx: ALU register-register.
- 11xxxx: ALU register-literal.
- 01xxxx: memory; opcode[3]=0 is load, 1 is store.
- 100000: branch, PC <= PC + literal.
- 101111: halt.
- any other 10xxxx: illegal.
REQ-013 States SHALL be FETCH_ADDR, FETCH_WAIT, DECODE, EXECUTE, WRITEBACK, MEM_DATA, MEM_ADDR, MEM_WAIT, BRANCH, HALT and ERROR.
REQ-014 FETCH_ADDR SHALL assert fetch=1 and wrAdd=1 for one cycle, then go to FETCH_WAIT.
REQ-015 FETCH_WAIT SHALL assert mem_req=1 and AddCon=1.
- On Valid: load IR from data, pulse increment=1 for that cycle, go to DECODE.
REQ-016 DECODE SHALL last one cycle and dispatch:
- ALU class to EXECUTE.
- Load to MEM_ADDR.
- Store to MEM_DATA.
- Branch to BRANCH.
- Halt to HALT.
- Illegal to ERROR.
REQ-017 EXECUTE SHALL assert wrData=1. WRITEBACK SHALL assert DataBus_En=1, DataCon=1, store_en=0 and regEn=1 with oppA as destination, then go to FETCH_ADDR.
REQ-018 MEM_DATA SHALL drive oppA=IR oppB field and literal=0 (ALU passes the register value), assert wrData=1, then go to MEM_ADDR.
REQ-019 MEM_ADDR SHALL drive oppA = IR base field and literal = offset, assert wrAdd=1, then go to MEM_WAIT.
REQ-020 MEM_WAIT SHALL assert mem_req=1 and AddCon=1.
- Store additionally asserts DataBus_En=1 and mem_we=1.
- On Valid, a load asserts regEn=1 and store_en=1 in the same cycle.
- On Valid, both load and store then go to FETCH_ADDR.
REQ-021 BRANCH SHALL assert Branch_En=1 with the ALU add selected and load the result into the PC via the PC load path, then go to FETCH_ADDR.
REQ-022 The memory-wait counter SHALL clear on entry to FETCH_WAIT or MEM_WAIT and increment each cycle without Valid.
- On reaching TIMEOUT the controller goes to ERROR; mem_req drops next cycle.
REQ-023 Valid SHALL be ignored outside FETCH_WAIT and MEM_WAIT.
- Valid in the same cycle the counter reaches TIMEOUT counts as success.
REQ-024 HALT and ERROR SHALL be terminal: only reset leaves them. halted=1 in HALT; error=1 in ERROR.
REQ-025 Every strobe not listed for a state SHALL be 0 in that state. All outputs SHALL be registered-state decodes with no combinational path from Valid to mem_req.

Reset
REQ-026 Reset SHALL:
- Force FETCH_ADDR, IR=0 and counter=0.
- Drive all strobes, halted and error to 0 from the next edge.
- Take effect from any state, including mid-MEM_WAIT, and abandon the pending request without a write.

Structure
REQ-027 The opcode-class encodings, the state enumeration and the field bit positions SHALL live in the shared cpu package.
REQ-028 The wait counter SHALL be a sub-module wait_timer, with inputs clear, enable and terminal count, and output expired.

Verification
REQ-029 ADD r3,r1,r2 (opcode 000000), Valid on 2nd FETCH_WAIT cycle -> sequence FETCH_ADDR, FETCH_WAIT x2, DECODE, EXECUTE, WRITEBACK; regEn one cycle; increment exactly once.
REQ-030 Load, opcode 010000, base r2, offset 0xFFFC -> literal=0xFFFFFFFC in MEM_ADDR; regEn and store_en high in the Valid cycle.
REQ-031 Store, opcode 011000 -> MEM_DATA literal=0, then MEM_WAIT with mem_we=1 and DataBus_En=1 until Valid.
REQ-032 Valid withheld in FETCH_WAIT with TIMEOUT=16 -> ERROR after 16 cycles and error=1. A separate case with Valid on cycle 16 -> DECODE.
REQ-033 Reset asserted during store MEM_WAIT -> next cycle FETCH_ADDR, mem_we=0, no Valid-driven write.
REQ-034 Halt opcode 101111 -> halted=1; further Valid pulses cause no state change.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared cpu definitions: instruction field positions, opcode classes
// and the controller state enumeration.
package control_unit_pkg;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RA_MSB  = 25;
    localparam int RA_LSB  = 21;
    localparam int RB_MSB  = 20;
    localparam int RB_LSB  = 16;
    localparam int LIT_MSB = 15;
    localparam int LIT_LSB = 0;

    localparam logic [5:0] OP_ADD    = 6'b000000;
    localparam logic [5:0] OP_BRANCH = 6'b100000;
    localparam logic [5:0] OP_HALT   = 6'b101111;

    typedef enum logic [3:0] {
        FETCH_ADDR = 4'd0,
        FETCH_WAIT = 4'd1,
        DECODE     = 4'd2,
        EXECUTE    = 4'd3,
        WRITEBACK  = 4'd4,
        MEM_DATA   = 4'd5,
        MEM_ADDR   = 4'd6,
        MEM_WAIT   = 4'd7,
        BRANCH     = 4'd8,
        HALT       = 4'd9,
        ERROR      = 4'd10
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_HALT    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_e;

    function automatic op_class_e op_class(input logic [5:0] op);
        op_class_e c;
        c = CLS_ILLEGAL;
        unique casez (op)
            6'b00????: c = CLS_ALU;
            6'b11????: c = CLS_ALU;
            6'b010???: c = CLS_LOAD;
            6'b011???: c = CLS_STORE;
            OP_BRANCH: c = CLS_BRANCH;
            OP_HALT:   c = CLS_HALT;
            default:   c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-wait cycle counter; expired fires on the cycle that would
// complete the tc-th consecutive wait cycle without a completion.
module wait_timer #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] tc,
    output logic          expired
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == tc - 1'b1);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU controller: fetch/decode/execute sequencing, memory
// handshakes with timeout, and strobe decode for the datapath.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int AWIDTH  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             Valid,
    output logic [5:0]       opcode,
    output logic [4:0]       oppA,
    output logic [4:0]       oppB,
    output logic [WIDTH-1:0] literal,
    output logic             regEn,
    output logic             increment,
    output logic             wrData,
    output logic             wrAdd,
    output logic             fetch,
    output logic             Branch_En,
    output logic             store_en,
    output logic             DataBus_En,
    output logic             AddCon,
    output logic             DataCon,
    output logic             mem_req,
    output logic             mem_we,
    output logic             halted,
    output logic             error
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT);

    if (WIDTH < 32) begin : g_width_check
        $error("control_unit: WIDTH must hold a 32-bit instruction");
    end
    if (AWIDTH > WIDTH) begin : g_awidth_check
        $error("control_unit: address is loaded from the data path");
    end
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("control_unit: TIMEOUT must be at least 1");
    end

    state_e           state;
    logic             quiet;
    logic [WIDTH-1:0] ir;
    op_class_e        cls;
    logic             is_store;
    logic             in_wait;
    logic             t_clear;
    logic             t_en;
    logic             expired;

    assign cls      = op_class(ir[OP_MSB:OP_LSB]);
    assign is_store = (cls == CLS_STORE);
    assign in_wait  = (state == FETCH_WAIT) || (state == MEM_WAIT);
    assign t_clear  = (state == FETCH_ADDR) || (state == MEM_ADDR);
    assign t_en     = in_wait && !Valid;

    wait_timer #(
        .CW(CW)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (t_clear),
        .enable (t_en),
        .tc     (TC),
        .expired(expired)
    );

    // quiet marks the cycle after a reset edge: strobes stay low and
    // FETCH_ADDR is held so its own strobes still get a full cycle.
    always_ff @(posedge clk) begin
        quiet <= reset;
        if (reset) begin
            state <= FETCH_ADDR;
            ir    <= '0;
        end else begin
            unique case (state)
                FETCH_ADDR: begin
                    if (!quiet) state <= FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    if (Valid) begin
                        ir    <= data;
                        state <= DECODE;
                    end else if (expired) begin
                        state <= ERROR;
                    end
                end
                DECODE: begin
                    unique case (cls)
                        CLS_ALU:    state <= EXECUTE;
                        CLS_LOAD:   state <= MEM_ADDR;
                        CLS_STORE:  state <= MEM_DATA;
                        CLS_BRANCH: state <= BRANCH;
                        CLS_HALT:   state <= HALT;
                        default:    state <= ERROR;
                    endcase
                end
                EXECUTE:   state <= WRITEBACK;
                WRITEBACK: state <= FETCH_ADDR;
                MEM_DATA:  state <= MEM_ADDR;
                MEM_ADDR:  state <= MEM_WAIT;
                MEM_WAIT: begin
                    if (Valid) begin
                        state <= FETCH_ADDR;
                    end else if (expired) begin
                        state <= ERROR;
                    end
                end
                BRANCH:    state <= FETCH_ADDR;
                HALT:      state <= HALT;
                ERROR:     state <= ERROR;
                default:   state <= ERROR;
            endcase
        end
    end

    always_comb begin
        opcode     = ir[OP_MSB:OP_LSB];
        oppA       = ir[RA_MSB:RA_LSB];
        oppB       = ir[RB_MSB:RB_LSB];
        literal    = {{(WIDTH-16){ir[LIT_MSB]}}, ir[LIT_MSB:LIT_LSB]};
        regEn      = 1'b0;
        increment  = 1'b0;
        wrData     = 1'b0;
        wrAdd      = 1'b0;
        fetch      = 1'b0;
        Branch_En  = 1'b0;
        store_en   = 1'b0;
        DataBus_En = 1'b0;
        AddCon     = 1'b0;
        DataCon    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        halted     = 1'b0;
        error      = 1'b0;
        if (!quiet) begin
            unique case (state)
                FETCH_ADDR: begin
                    fetch = 1'b1;
                    wrAdd = 1'b1;
                end
                FETCH_WAIT: begin
                    mem_req   = 1'b1;
                    AddCon    = 1'b1;
                    increment = Valid;
                end
                EXECUTE: wrData = 1'b1;
                WRITEBACK: begin
                    DataBus_En = 1'b1;
                    DataCon    = 1'b1;
                    regEn      = 1'b1;
                end
                // Store data goes through the ALU as reg + 0.
                MEM_DATA: begin
                    opcode  = OP_ADD;
                    oppA    = ir[RB_MSB:RB_LSB];
                    literal = '0;
                    wrData  = 1'b1;
                end
                MEM_ADDR: begin
                    opcode = OP_ADD;
                    wrAdd  = 1'b1;
                end
                MEM_WAIT: begin
                    mem_req = 1'b1;
                    AddCon  = 1'b1;
                    if (is_store) begin
                        DataBus_En = 1'b1;
                        mem_we     = 1'b1;
                    end else begin
                        oppA     = ir[RB_MSB:RB_LSB];
                        regEn    = Valid;
                        store_en = Valid;
                    end
                end
                BRANCH: begin
                    opcode    = OP_ADD;
                    Branch_En = 1'b1;
                end
                HALT:    halted = 1'b1;
                ERROR:   error  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
